// File: rtl/player_link_pkg.sv
// ============================================================================
// Module      : player_link_pkg
// Description : Definitions shared by the player-link sender and receiver:
//               lane codes, player-state byte bit positions, the UART RX
//               state encoding and small byte-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package player_link_pkg;

    // Lane field bounds inside the player-state byte
    localparam int LANE_MSB = 3;
    localparam int LANE_LSB = 0;

    typedef logic [LANE_MSB-LANE_LSB:0] lane_field_t;

    // Lane codes; LANE_RESET is what the sender transmits from its RESET state
    localparam lane_field_t LANE_RESET   = 4'd0;
    localparam lane_field_t LANE1        = 4'd1;
    localparam lane_field_t LANE2        = 4'd2;
    localparam lane_field_t LANE3        = 4'd3;
    localparam lane_field_t LANE4        = 4'd4;
    localparam lane_field_t LANE5        = 4'd5;
    localparam lane_field_t LANE6        = 4'd6;
    localparam lane_field_t LANE_DEFAULT = 4'd3;

    // Player-state byte layout: {remote_reset, reserved, fire, type, lane[3:0]}
    localparam int BIT_RST  = 7;
    localparam int BIT_RSVD = 6;
    localparam int BIT_FIRE = 5;
    localparam int BIT_TYPE = 4;

    // UART receiver states, explicitly encoded
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True for lane codes a sender may legally transmit
    function automatic logic lane_in_range(input lane_field_t f);
        logic ok;
        case (f)
            LANE_RESET, LANE1, LANE2, LANE3, LANE4, LANE5, LANE6: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Maps a lane code to the 3-bit game lane; the RESET code means "centre"
    function automatic logic [2:0] decode_lane(input lane_field_t f);
        logic [2:0] l;
        case (f)
            LANE1, LANE2, LANE3, LANE4, LANE5, LANE6: l = f[2:0];
            default:                                  l = LANE_DEFAULT[2:0];
        endcase
        return l;
    endfunction

    // A byte is usable when the reserved bit is clear and the lane is legal
    function automatic logic packet_ok(input logic [7:0] b);
        return (b[BIT_RSVD] == 1'b0) && lane_in_range(b[LANE_MSB:LANE_LSB]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/player_link_receiver_uart_rx.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver. Synchronises the raw RX line, finds
//               the start bit, samples eight data bits LSB-first at bit
//               centres and checks the stop bit.
// Ports       : clk        - system clock, rising edge
//               clean_rst  - asynchronous active-high reset
//               rx_serial  - raw UART line, idle high, asynchronous
//               data       - last received byte (stable while idle)
//               byte_valid - one-cycle pulse, stop bit was high
//               frame_err  - one-cycle pulse, stop bit was low
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import player_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       clean_rst,
    input  logic       rx_serial,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int                  c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF     = c_CNT_W'((CLKS_PER_BIT - 1) / 2);

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [1:0]         r_sync;
    logic [1:0]         r_flush;
    logic               r_armed;
    logic               r_rx_prev;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_byte_valid;
    logic               r_frame_err;

    logic               w_rx_s;
    logic               w_fall;
    logic               w_hit_half;
    logic               w_hit_bit;
    logic               w_baud_clr;
    logic               w_shift_en;
    logic               w_stop_sample;

    // Two-flop synchroniser, idle-high reset value
    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_serial};
        end
    end

    assign w_rx_s = r_sync[1];

    // The synchroniser's reset value is not a real observation of the line.
    // r_flush marks when rx_s carries a genuine sample; only a genuine high
    // arms start detection, so a frame caught mid-way by reset is ignored
    // until the line idles high and falls again.
    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_flush   <= 2'b00;
            r_armed   <= 1'b0;
            r_rx_prev <= 1'b1;
        end else begin
            r_flush   <= {r_flush[0], 1'b1};
            r_rx_prev <= w_rx_s;
            if (r_flush[1] && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall     = r_armed & r_rx_prev & ~w_rx_s;
    assign w_hit_half = (r_baud == c_HALF);
    assign w_hit_bit  = (r_baud == c_BIT_LAST);

    // State register
    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // High at mid start bit means the fall was only a glitch
                if (w_hit_half) begin
                    w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_hit_bit && (r_bit == 3'd7)) begin
                    w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_hit_bit) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        w_baud_clr    = 1'b1;
        w_shift_en    = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_baud_clr = 1'b1;
            end
            RX_START: begin
                w_baud_clr = w_hit_half;
            end
            RX_DATA: begin
                w_baud_clr = w_hit_bit;
                w_shift_en = w_hit_bit;
            end
            RX_STOP: begin
                w_baud_clr    = w_hit_bit;
                w_stop_sample = w_hit_bit;
            end
            default: begin
                w_baud_clr = 1'b1;
            end
        endcase
    end

    // Baud counter, bit counter, shift register and result pulses
    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_baud       <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_baud <= w_baud_clr ? '0 : (r_baud + c_CNT_W'(1));

            if (r_state != RX_DATA) begin
                r_bit <= 3'd0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end

            r_byte_valid <= w_stop_sample &  w_rx_s;
            r_frame_err  <= w_stop_sample & ~w_rx_s;
        end
    end

    assign data       = r_shift;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/player_link_receiver.sv
// ============================================================================
// Module      : player_link_receiver
// Description : Decodes player-state bytes from the controller board's UART
//               into registered game controls, drops malformed bytes and
//               reports link loss through a watchdog.
// Ports       : clk             - system clock, rising edge
//               clean_rst       - asynchronous active-high reset
//               rx_serial       - raw UART line, idle high
//               lane            - current lane 1..6 (reset 3)
//               projectile_type - packet type bit
//               fire_pulse      - one-cycle pulse on a rising fire bit
//               remote_reset    - remote-reset bit of last valid packet
//               packet_strobe   - one-cycle pulse per accepted packet
//               bad_packet      - one-cycle pulse per rejected byte/frame
//               link_alive      - packets seen within TIMEOUT_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_link_receiver
    import player_link_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 10416,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       clean_rst,
    input  logic       rx_serial,
    output logic [2:0] lane,
    output logic       projectile_type,
    output logic       fire_pulse,
    output logic       remote_reset,
    output logic       packet_strobe,
    output logic       bad_packet,
    output logic       link_alive
);

    localparam int                 c_WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES);

    logic [7:0]        w_data;
    logic              w_byte_valid;
    logic              w_frame_err;
    logic              w_pkt_ok;
    logic              w_accept;
    logic              w_reject;
    logic              w_wd_expired;

    logic [2:0]        r_lane;
    logic              r_type;
    logic              r_fire_pulse;
    logic              r_fire_prev;
    logic              r_remote_reset;
    logic              r_packet_strobe;
    logic              r_bad_packet;
    logic              r_link_alive;
    logic [c_WD_W-1:0] r_wd;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .clean_rst  (clean_rst),
        .rx_serial  (rx_serial),
        .data       (w_data),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err)
    );

    assign w_pkt_ok     = packet_ok(w_data);
    assign w_accept     = w_byte_valid &  w_pkt_ok;
    assign w_reject     = w_frame_err | (w_byte_valid & ~w_pkt_ok);
    assign w_wd_expired = (r_wd == c_WD_MAX);

    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_lane          <= decode_lane(LANE_RESET);
            r_type          <= 1'b0;
            r_fire_pulse    <= 1'b0;
            r_fire_prev     <= 1'b0;
            r_remote_reset  <= 1'b0;
            r_packet_strobe <= 1'b0;
            r_bad_packet    <= 1'b0;
            r_link_alive    <= 1'b0;
            r_wd            <= '0;
        end else begin
            r_packet_strobe <= w_accept;
            r_bad_packet    <= w_reject;
            r_fire_pulse    <= 1'b0;

            // An accept in the expiry cycle takes priority over the timeout
            if (w_accept) begin
                r_lane         <= decode_lane(w_data[LANE_MSB:LANE_LSB]);
                r_type         <= w_data[BIT_TYPE];
                r_remote_reset <= w_data[BIT_RST];
                r_fire_pulse   <= w_data[BIT_FIRE] & ~r_fire_prev;
                r_fire_prev    <= w_data[BIT_FIRE];
                r_link_alive   <= 1'b1;
                r_wd           <= '0;
            end else if (w_wd_expired) begin
                // Lost link: drop live controls, keep lane/type where they were
                r_link_alive   <= 1'b0;
                r_remote_reset <= 1'b0;
                r_fire_prev    <= 1'b0;
            end else begin
                r_wd <= r_wd + c_WD_W'(1);
            end
        end
    end

    assign lane            = r_lane;
    assign projectile_type = r_type;
    assign fire_pulse      = r_fire_pulse;
    assign remote_reset    = r_remote_reset;
    assign packet_strobe   = r_packet_strobe;
    assign bad_packet      = r_bad_packet;
    assign link_alive      = r_link_alive;

endmodule

`default_nettype wire

// File: tb/tb_player_link_receiver.sv
// ============================================================================
// Module      : tb_player_link_receiver
// Description : Directed self-checking bench for player_link_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_link_receiver;

    localparam int CPB = 16;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       clean_rst;
    logic       rx_serial;
    logic [2:0] lane;
    logic       projectile_type;
    logic       fire_pulse;
    logic       remote_reset;
    logic       packet_strobe;
    logic       bad_packet;
    logic       link_alive;

    int n_assert = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_bad    = 0;
    int n_fire   = 0;
    int s0, b0, f0;

    always #5 clk = ~clk;

    player_link_receiver #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .clean_rst       (clean_rst),
        .rx_serial       (rx_serial),
        .lane            (lane),
        .projectile_type (projectile_type),
        .fire_pulse      (fire_pulse),
        .remote_reset    (remote_reset),
        .packet_strobe   (packet_strobe),
        .bad_packet      (bad_packet),
        .link_alive      (link_alive)
    );

    // Pulse counters: count high cycles, so a stretched pulse counts twice
    always @(negedge clk) begin
        if (packet_strobe) n_strobe <= n_strobe + 1;
        if (bad_packet)    n_bad    <= n_bad + 1;
        if (fire_pulse)    n_fire   <= n_fire + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic snap();
        s0 = n_strobe;
        b0 = n_bad;
        f0 = n_fire;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] fire_bytes [4] = '{8'h23, 8'h23, 8'h03, 8'h23};
    int         fire_exp   [4] = '{1, 0, 0, 1};
    logic [7:0] bad_bytes  [3] = '{8'h07, 8'h43, 8'h10};
    logic       bad_stop   [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clean_rst = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_lane",   32'(lane), 3);
        check_val("rst_alive",  32'(link_alive), 0);
        check_val("rst_strobe", 32'(packet_strobe), 0);
        check_val("rst_bad",    32'(bad_packet), 0);
        check_val("rst_fire",   32'(fire_pulse), 0);
        check_val("rst_remote", 32'(remote_reset), 0);
        check_val("rst_type",   32'(projectile_type), 0);
        clean_rst = 1'b0;
        repeat (20) @(negedge clk);
        check_val("idle_strobes", 32'(n_strobe), 0);

        // First packet
        snap();
        send_byte(8'h05, 1'b1);
        check_val("p05_lane",   32'(lane), 5);
        check_val("p05_strobe", 32'(n_strobe - s0), 1);
        check_val("p05_alive",  32'(link_alive), 1);
        check_val("p05_bad",    32'(n_bad - b0), 0);

        // Fire edge detection
        for (int i = 0; i < 4; i++) begin
            snap();
            send_byte(fire_bytes[i], 1'b1);
            check_val($sformatf("fire%0d_pulse", i), 32'(n_fire - f0), 32'(fire_exp[i]));
            check_val($sformatf("fire%0d_lane", i),  32'(lane), 3);
        end

        // Type bit, then rejected bytes and a framing error
        send_byte(8'h14, 1'b1);
        check_val("p14_type", 32'(projectile_type), 1);
        check_val("p14_lane", 32'(lane), 4);
        snap();
        for (int i = 0; i < 3; i++) send_byte(bad_bytes[i], bad_stop[i]);
        check_val("bad_count",  32'(n_bad - b0), 3);
        check_val("bad_strobe", 32'(n_strobe - s0), 0);
        check_val("bad_lane",   32'(lane), 4);
        check_val("bad_type",   32'(projectile_type), 1);

        // Remote reset and lane-0 default
        send_byte(8'h80, 1'b1);
        check_val("p80_remote", 32'(remote_reset), 1);
        check_val("p80_lane",   32'(lane), 3);
        send_byte(8'h01, 1'b1);
        check_val("p01_remote", 32'(remote_reset), 0);
        check_val("p01_lane",   32'(lane), 1);

        // Watchdog boundary
        send_byte(8'h06, 1'b1);
        check_val("p06_lane", 32'(lane), 6);
        repeat (1900) @(negedge clk);
        check_val("wd_before_alive", 32'(link_alive), 1);
        repeat (150) @(negedge clk);
        check_val("wd_after_alive", 32'(link_alive), 0);
        check_val("wd_after_lane",  32'(lane), 6);

        // Short glitch is ignored silently
        snap();
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        repeat (40) @(negedge clk);
        check_val("glitch_strobe", 32'(n_strobe - s0), 0);
        check_val("glitch_bad",    32'(n_bad - b0), 0);

        // Watchdog expiry clears remote_reset and the fire history
        snap();
        send_byte(8'hA1, 1'b1);
        check_val("pA1_remote", 32'(remote_reset), 1);
        check_val("pA1_fire",   32'(n_fire - f0), 1);
        repeat (TMO + 100) @(negedge clk);
        check_val("wd2_remote", 32'(remote_reset), 0);
        check_val("wd2_alive",  32'(link_alive), 0);
        snap();
        send_byte(8'h21, 1'b1);
        check_val("p21_fire_after_wd", 32'(n_fire - f0), 1);
        snap();
        send_byte(8'h21, 1'b1);
        check_val("p21_fire_repeat", 32'(n_fire - f0), 0);

        // Reset in the middle of data bit 6 of 0x25
        snap();
        fork
            send_byte(8'h25, 1'b1);
            begin
                repeat (116) @(negedge clk);
                clean_rst = 1'b1;
                @(negedge clk);
                check_val("mid_rst_lane",  32'(lane), 3);
                check_val("mid_rst_alive", 32'(link_alive), 0);
                repeat (3) @(negedge clk);
                clean_rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check_val("mid_rst_strobe", 32'(n_strobe - s0), 0);
        check_val("mid_rst_bad",    32'(n_bad - b0), 0);
        check_val("mid_rst_lane2",  32'(lane), 3);

        snap();
        send_byte(8'h02, 1'b1);
        check_val("p02_lane",   32'(lane), 2);
        check_val("p02_strobe", 32'(n_strobe - s0), 1);
        check_val("p02_alive",  32'(link_alive), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
